// File: rtl/shared_pkg.sv
// shared_pkg: word width, FIFO depth and read-counter width shared by the FIFO and its stream reader.
package shared_pkg;
  localparam int FIFO_WIDTH = 16;
  localparam int FIFO_DEPTH = 8;
  localparam int RD_COUNT_W = 16;
endpackage

// File: rtl/fifo_stream_reader_if.sv
// fifo_stream_reader_if: FIFO read port plus valid/ready output stream seen by the reader.
interface fifo_stream_reader_if;
  import shared_pkg::*;
  logic rd_en;
  logic empty;
  logic underflow;
  logic [FIFO_WIDTH-1:0] data_out;
  logic [FIFO_WIDTH-1:0] m_data;
  logic m_valid;
  logic m_ready;
  modport master (output rd_en, m_data, m_valid, input empty, underflow, data_out, m_ready);
  modport slave (input rd_en, m_data, m_valid, output empty, underflow, data_out, m_ready);
endinterface

// File: rtl/fifo_rd_buf.sv
// fifo_rd_buf: two-entry output buffer absorbing the FIFO's one-cycle read latency.
module fifo_rd_buf
  import shared_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic wr,
  input  logic pop,
  input  logic [FIFO_WIDTH-1:0] wdata,
  output logic [1:0] occ,
  output logic [FIFO_WIDTH-1:0] rdata
);
  logic [FIFO_WIDTH-1:0] mem [2];
  logic head, tail;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      mem[0] <= '0;
      mem[1] <= '0;
      head <= 1'b0;
      tail <= 1'b0;
      occ <= 2'd0;
    end else begin
      if (wr) begin
        mem[tail] <= wdata;
        tail <= ~tail;
      end
      if (pop) head <= ~head;
      occ <= occ + {1'b0, wr} - {1'b0, pop};
    end
  assign rdata = mem[head];
endmodule

// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader: drains the FIFO read port onto a valid/ready stream at one word per cycle.
// Defining FIFO_RD_STATS_EN adds the rd_count pop counter output.
module fifo_stream_reader
  import shared_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  fifo_stream_reader_if.master bus,
  output logic rd_err
`ifdef FIFO_RD_STATS_EN
  ,
  output logic [RD_COUNT_W-1:0] rd_count
`endif
);
  logic inflight, pop;
  logic [1:0] occ;
  logic [2:0] level;
  assign pop = bus.m_valid && bus.m_ready;
  // occupancy the buffer will have next cycle; a read is allowed only if a slot remains for it
  assign level = {1'b0, occ} + {2'b0, inflight} - {2'b0, pop};
  assign bus.rd_en = rst_n && enable && !bus.empty && level < 3'd2;
  assign bus.m_valid = occ != 2'd0;
  fifo_rd_buf u_buf (
    .clk(clk),
    .rst_n(rst_n),
    .wr(inflight),
    .pop(pop),
    .wdata(bus.data_out),
    .occ(occ),
    .rdata(bus.m_data)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      inflight <= 1'b0;
      rd_err <= 1'b0;
    end else begin
      inflight <= bus.rd_en;
      rd_err <= rd_err | bus.underflow;
    end
`ifdef FIFO_RD_STATS_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) rd_count <= '0;
    else rd_count <= rd_count + {{(RD_COUNT_W-1){1'b0}}, pop};
`endif
endmodule

// File: tb/tb_fifo_stream_reader.sv
// tb_fifo_stream_reader: directed bench with a behavioural FIFO model feeding fifo_stream_reader.
module tb_fifo_stream_reader;
  import shared_pkg::*;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic enable = 1'b0;
  logic rd_err;
  logic uf_reg = 1'b0;
  logic uf_inj = 1'b0;
  logic [FIFO_WIDTH-1:0] mem [0:131071];
  int wr_total = 0;
  int rd_total = 0;
  int cyc = 0;
  int n_rd = 0;
  int n_chk = 0;
  int n_fail = 0;
  int lvl;
  logic [FIFO_WIDTH-1:0] got [$];
  int pop_cyc [$];
`ifdef FIFO_RD_STATS_EN
  logic [RD_COUNT_W-1:0] rd_count;
`endif
  fifo_stream_reader_if bus ();
  fifo_stream_reader dut (
    .clk(clk),
    .rst_n(rst_n),
    .enable(enable),
    .bus(bus),
    .rd_err(rd_err)
`ifdef FIFO_RD_STATS_EN
    ,
    .rd_count(rd_count)
`endif
  );
  always #5 clk = ~clk;
  assign bus.empty = (wr_total == rd_total);
  assign bus.underflow = uf_reg | uf_inj;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_chk++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input logic [FIFO_WIDTH-1:0] v);
    mem[wr_total[16:0]] = v;
    wr_total++;
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // FIFO model: registered read data and underflow; its reset discards unread words
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rd_total <= wr_total;
      uf_reg <= 1'b0;
    end else begin
      uf_reg <= bus.rd_en && bus.empty;
      if (bus.rd_en && !bus.empty) begin
        bus.data_out <= mem[rd_total[16:0]];
        rd_total <= rd_total + 1;
      end
    end

  always @(negedge clk)
    if (rst_n) begin
      if (bus.m_valid && bus.m_ready) begin
        got.push_back(bus.m_data);
        pop_cyc.push_back(cyc);
      end
      if (bus.rd_en) n_rd++;
      lvl = int'(dut.u_buf.occ) + int'(dut.inflight) - int'(bus.m_valid && bus.m_ready);
      if (lvl > 2) check("occ_bound", lvl, 2);
      if (dut.u_buf.occ == 2'd2 && dut.inflight && bus.m_valid && bus.m_ready) check("cap_pop_full", 1, 0);
    end

  initial begin
    bus.m_ready = 1'b0;
    bus.data_out = '0;
    ticks(2);
    check("rst_rd_en", bus.rd_en, 0);
    check("rst_m_valid", bus.m_valid, 0);
    check("rst_m_data", bus.m_data, 0);
    check("rst_rd_err", rd_err, 0);
    rst_n = 1'b1;
    enable = 1'b1;
    ticks(3);
    check("idle_no_read", n_rd, 0);
    bus.m_ready = 1'b1;
    got.delete();
    pop_cyc.delete();
    n_rd = 0;
    for (int i = 1; i <= 8; i++) push(FIFO_WIDTH'(i));
    ticks(14);
    check("stream_cnt", got.size(), 8);
    for (int i = 0; i < 8; i++) check("stream_word", got[i], i + 1);
    check("stream_b2b", pop_cyc[7] - pop_cyc[0], 7);
    check("stream_rd_cnt", n_rd, 8);
    bus.m_ready = 1'b0;
    got.delete();
    n_rd = 0;
    for (int i = 0; i < 4; i++) push(16'h0011 + FIFO_WIDTH'(i));
    ticks(5);
    check("bp_rd_en", n_rd, 2);
    check("bp_head", bus.m_data, 16'h0011);
    check("bp_valid", bus.m_valid, 1);
    check("bp_fifo_left", wr_total - rd_total, 2);
    check("bp_no_pop", got.size(), 0);
    bus.m_ready = 1'b1;
    ticks(8);
    check("bp_cnt", got.size(), 4);
    for (int i = 0; i < 4; i++) check("bp_word", got[i], 16'h0011 + i);
    got.delete();
    for (int i = 0; i < 6; i++) push(16'h0021 + FIFO_WIDTH'(i));
    for (int i = 0; i < 20; i++) begin
      bus.m_ready = (i % 2 == 0);
      ticks(1);
    end
    bus.m_ready = 1'b1;
    ticks(4);
    check("alt_cnt", got.size(), 6);
    for (int i = 0; i < 6; i++) check("alt_word", got[i], 16'h0021 + i);
    got.delete();
    for (int i = 0; i < 3; i++) push(16'h0031 + FIFO_WIDTH'(i));
    ticks(1);
    check("gate_inflight", dut.inflight, 1);
    enable = 1'b0;
    n_rd = 0;
    ticks(4);
    check("gate_no_rd", n_rd, 0);
    check("gate_cnt", got.size(), 1);
    check("gate_word", got[0], 16'h0031);
    check("gate_fifo_left", wr_total - rd_total, 2);
    enable = 1'b1;
    ticks(6);
    check("resume_cnt", got.size(), 3);
    check("resume_w1", got[1], 16'h0032);
    check("resume_w2", got[2], 16'h0033);
    uf_inj = 1'b1;
    ticks(1);
    uf_inj = 1'b0;
    check("uf_set", rd_err, 1);
    ticks(5);
    check("uf_sticky", rd_err, 1);
    bus.m_ready = 1'b0;
    for (int i = 0; i < 4; i++) push(16'h0041 + FIFO_WIDTH'(i));
    ticks(5);
    check("pre_rst_occ", dut.u_buf.occ, 2);
    rst_n = 1'b0;
    #1;
    check("mid_rst_rd_en", bus.rd_en, 0);
    check("mid_rst_valid", bus.m_valid, 0);
    check("mid_rst_data", bus.m_data, 0);
    check("mid_rst_err", rd_err, 0);
    ticks(1);
    rst_n = 1'b1;
    n_rd = 0;
    ticks(3);
    check("post_rst_no_rd", n_rd, 0);
    check("post_rst_valid", bus.m_valid, 0);
    got.delete();
    bus.m_ready = 1'b1;
    push(16'h0055);
    ticks(4);
    check("post_rst_cnt", got.size(), 1);
    check("post_rst_word", got[0], 16'h0055);
`ifdef FIFO_RD_STATS_EN
    check("stats_one", rd_count, 1);
    for (int i = 0; i < 65536; i++) push(FIFO_WIDTH'(i));
    ticks(65536 + 6);
    check("stats_wrap", rd_count, 1);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
